// File: rtl/iob_bus_arbiter_if.sv
// Native-bus bundle around the two-master/one-slave arbiter.
// The master modport is the arbiter's view; the slave modport is the view of the surrounding masters and memory.
interface iob_bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  m0_valid;
  logic [ADDR_W-1:0]     m0_addr;
  logic [DATA_W-1:0]     m0_wdata;
  logic [DATA_W/8-1:0]   m0_wstrb;
  logic [DATA_W-1:0]     m0_rdata;
  logic                  m0_ready;

  logic                  m1_valid;
  logic [ADDR_W-1:0]     m1_addr;
  logic [DATA_W-1:0]     m1_wdata;
  logic [DATA_W/8-1:0]   m1_wstrb;
  logic [DATA_W-1:0]     m1_rdata;
  logic                  m1_ready;

  logic                  s_valid;
  logic [ADDR_W-1:0]     s_addr;
  logic [DATA_W-1:0]     s_wdata;
  logic [DATA_W/8-1:0]   s_wstrb;
  logic [DATA_W-1:0]     s_rdata;
  logic                  s_ready;
  logic                  busy;

  modport master (
    input  m0_valid, m0_addr, m0_wdata, m0_wstrb,
    output m0_rdata, m0_ready,
    input  m1_valid, m1_addr, m1_wdata, m1_wstrb,
    output m1_rdata, m1_ready,
    output s_valid, s_addr, s_wdata, s_wstrb,
    input  s_rdata, s_ready,
    output busy
  );

  modport slave (
    output m0_valid, m0_addr, m0_wdata, m0_wstrb,
    input  m0_rdata, m0_ready,
    output m1_valid, m1_addr, m1_wdata, m1_wstrb,
    input  m1_rdata, m1_ready,
    input  s_valid, s_addr, s_wdata, s_wstrb,
    output s_rdata, s_ready,
    input  busy
  );
endinterface

// File: rtl/iob_bus_arbiter.sv
// Two-master (instruction/data) to one-slave native-bus arbiter, one transaction outstanding.
// RR=1 alternates on ties; RR=0 gives the data master (m1) fixed priority.
module iob_bus_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RR     = 1
) (
  input  logic              clk,
  input  logic              resetn,
  iob_bus_arbiter_if.master bus
);
  localparam int STRB_W = DATA_W / 8;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t              state_q, state_d;
  logic                grant_q, grant_d;
  logic                last_grant_q, last_grant_d;
  logic [ADDR_W-1:0]   s_addr_q, s_addr_d;
  logic [DATA_W-1:0]   s_wdata_q, s_wdata_d;
  logic [STRB_W-1:0]   s_wstrb_q, s_wstrb_d;
  logic                sel;
  logic                done;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      s_addr_q     <= '0;
      s_wdata_q    <= '0;
      s_wstrb_q    <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      s_addr_q     <= s_addr_d;
      s_wdata_q    <= s_wdata_d;
      s_wstrb_q    <= s_wstrb_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    s_addr_d     = s_addr_q;
    s_wdata_d    = s_wdata_q;
    s_wstrb_d    = s_wstrb_q;

    // Single requester wins outright; a tie goes to the non-last master or to m1.
    if (bus.m0_valid && bus.m1_valid) begin
      sel = (RR != 0) ? ~last_grant_q : 1'b1;
    end else begin
      sel = bus.m1_valid;
    end

    case (state_q)
      IDLE: begin
        if (bus.m0_valid || bus.m1_valid) begin
          state_d      = BUSY;
          grant_d      = sel;
          last_grant_d = sel;
          s_addr_d     = sel ? bus.m1_addr  : bus.m0_addr;
          s_wdata_d    = sel ? bus.m1_wdata : bus.m0_wdata;
          s_wstrb_d    = sel ? bus.m1_wstrb : bus.m0_wstrb;
        end
      end
      BUSY: begin
        if (bus.s_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Response steering is combinational so ready lands in the slave's s_ready cycle.
  assign done         = (state_q == BUSY) && bus.s_ready;
  assign bus.m0_ready = done && !grant_q;
  assign bus.m1_ready = done && grant_q;
  assign bus.m0_rdata = bus.m0_ready ? bus.s_rdata : '0;
  assign bus.m1_rdata = bus.m1_ready ? bus.s_rdata : '0;

  assign bus.s_valid  = (state_q == BUSY);
  assign bus.busy     = (state_q == BUSY);
  assign bus.s_addr   = s_addr_q;
  assign bus.s_wdata  = s_wdata_q;
  assign bus.s_wstrb  = s_wstrb_q;
endmodule

// File: tb/tb_iob_bus_arbiter.sv
// Directed bench: a round-robin and a fixed-priority arbiter driven by identical master/slave stimulus.
module tb_iob_bus_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          resetn;
  logic          m0_valid, m1_valid;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic [3:0]    m0_wstrb, m1_wstrb;
  logic [DW-1:0] s_rdata;
  logic          s_ready;

  int vectors     = 0;
  int miscompares = 0;

  iob_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) br ();
  iob_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bf ();

  assign br.m0_valid = m0_valid;  assign bf.m0_valid = m0_valid;
  assign br.m0_addr  = m0_addr;   assign bf.m0_addr  = m0_addr;
  assign br.m0_wdata = m0_wdata;  assign bf.m0_wdata = m0_wdata;
  assign br.m0_wstrb = m0_wstrb;  assign bf.m0_wstrb = m0_wstrb;
  assign br.m1_valid = m1_valid;  assign bf.m1_valid = m1_valid;
  assign br.m1_addr  = m1_addr;   assign bf.m1_addr  = m1_addr;
  assign br.m1_wdata = m1_wdata;  assign bf.m1_wdata = m1_wdata;
  assign br.m1_wstrb = m1_wstrb;  assign bf.m1_wstrb = m1_wstrb;
  assign br.s_rdata  = s_rdata;   assign bf.s_rdata  = s_rdata;
  assign br.s_ready  = s_ready;   assign bf.s_ready  = s_ready;

  iob_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RR(1)) u_rr (
    .clk    (clk),
    .resetn (resetn),
    .bus    (br.master)
  );

  iob_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RR(0)) u_fp (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bf.master)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    resetn   = 1'b0;
    m0_valid = 1'b1;  m0_addr = 32'h0000_0100;  m0_wdata = '0;  m0_wstrb = '0;
    m1_valid = 1'b0;  m1_addr = 32'h0000_1004;  m1_wdata = '0;  m1_wstrb = '0;
    s_rdata  = '0;    s_ready = 1'b0;

    // Reset held with m0 requesting
    repeat (2) tick();
    chk("rst_s_valid",  br.s_valid,  0);
    chk("rst_m0_ready", br.m0_ready, 0);
    chk("rst_s_addr",   br.s_addr,   0);
    chk("rst_fp_valid", bf.s_valid,  0);
    resetn = 1'b1;
    tick();
    chk("rel_s_valid", br.s_valid, 1);
    chk("rel_s_addr",  br.s_addr,  32'h0000_0100);
    chk("rel_busy",    br.busy,    1);
    s_rdata = 32'hA5A5_A5A5;
    s_ready = 1'b1;
    #1;
    chk("rel_m0_ready", br.m0_ready, 1);
    chk("rel_m0_rdata", br.m0_rdata, 32'hA5A5_A5A5);
    chk("rel_m1_ready", br.m1_ready, 0);
    m0_valid = 1'b0;
    tick();
    s_ready = 1'b0;
    #1;
    chk("rel_idle_valid", br.s_valid,  0);
    chk("rel_idle_ready", br.m0_ready, 0);

    // Single m1 read, slave answers two cycles after s_valid
    m1_valid = 1'b1;
    tick();
    chk("rd_s_valid", br.s_valid,  1);
    chk("rd_s_addr",  br.s_addr,   32'h0000_1004);
    chk("rd_s_wstrb", br.s_wstrb,  0);
    chk("rd_early",   br.m1_ready, 0);
    tick();
    chk("rd_wait_valid", br.s_valid,  1);
    chk("rd_wait_ready", br.m1_ready, 0);
    tick();
    s_ready = 1'b1;
    s_rdata = 32'hDEAD_BEEF;
    #1;
    chk("rd_m1_ready",    br.m1_ready, 1);
    chk("rd_m1_rdata",    br.m1_rdata, 32'hDEAD_BEEF);
    chk("rd_m0_ready",    br.m0_ready, 0);
    chk("rd_m0_rdata",    br.m0_rdata, 0);
    chk("rd_fp_m1_rdata", bf.m1_rdata, 32'hDEAD_BEEF);
    m1_valid = 1'b0;
    tick();
    s_ready = 1'b0;
    #1;
    chk("rd_pulse_end", br.m1_ready, 0);
    chk("rd_idle",      br.s_valid,  0);

    // Tie from reset release: RR alternates m0,m1,m0,m1; fixed priority keeps m1
    resetn   = 1'b0;
    m0_valid = 1'b1;
    m1_valid = 1'b1;
    #1;
    resetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("tie_rr_addr", br.s_addr, (i % 2 == 0) ? 32'h0000_0100 : 32'h0000_1004);
      chk("tie_fp_addr", bf.s_addr, 32'h0000_1004);
      s_ready = 1'b1;
      s_rdata = 32'hC000_0000 + i;
      #1;
      chk("tie_rr_m0_ready", br.m0_ready, (i % 2 == 0) ? 1 : 0);
      chk("tie_rr_m1_ready", br.m1_ready, (i % 2 == 0) ? 0 : 1);
      chk("tie_rr_rdata",    (i % 2 == 0) ? br.m0_rdata : br.m1_rdata, 32'hC000_0000 + i);
      chk("tie_fp_m1_ready", bf.m1_ready, 1);
      chk("tie_fp_m0_ready", bf.m0_ready, 0);
      if (i == 3) m1_valid = 1'b0;
      tick();
      s_ready = 1'b0;
      #1;
      chk("tie_idle", br.s_valid, 0);
    end
    tick();
    chk("fp_m0_alone_addr", bf.s_addr, 32'h0000_0100);
    s_ready = 1'b1;
    #1;
    chk("fp_m0_alone_ready", bf.m0_ready, 1);
    m0_valid = 1'b0;
    tick();
    s_ready = 1'b0;

    // Write pass-through, then s_ready held into IDLE (spurious)
    m1_valid = 1'b1;  m1_addr = 32'h0000_0020;  m1_wdata = 32'h1234_5678;  m1_wstrb = 4'h3;
    tick();
    chk("wr_s_addr",  br.s_addr,  32'h0000_0020);
    chk("wr_s_wdata", br.s_wdata, 32'h1234_5678);
    chk("wr_s_wstrb", br.s_wstrb, 4'h3);
    tick();
    chk("wr_hold_wdata", br.s_wdata, 32'h1234_5678);
    chk("wr_hold_wstrb", br.s_wstrb, 4'h3);
    chk("wr_hold_ready", br.m1_ready, 0);
    s_ready = 1'b1;
    #1;
    chk("wr_m1_ready", br.m1_ready, 1);
    m1_valid = 1'b0;
    tick();
    chk("spur_m1_ready", br.m1_ready, 0);
    chk("spur_m0_ready", br.m0_ready, 0);
    chk("spur_s_valid",  br.s_valid,  0);
    tick();
    chk("spur_stay_idle", br.s_valid,  0);
    chk("spur_m1_quiet",  br.m1_ready, 0);
    s_ready = 1'b0;

    // Reset asserted mid-BUSY, then arbitration restarts with m0 winning the tie
    m0_valid = 1'b1;
    tick();
    chk("mid_busy", br.s_valid, 1);
    s_ready = 1'b1;
    resetn  = 1'b0;
    #1;
    chk("mid_rst_valid",  br.s_valid,  0);
    chk("mid_rst_ready",  br.m0_ready, 0);
    chk("mid_rst_saddr",  br.s_addr,   0);
    s_ready  = 1'b0;
    m1_valid = 1'b1;
    m1_addr  = 32'h0000_1004;
    #2;
    resetn = 1'b1;
    tick();
    chk("post_rst_rr_addr", br.s_addr, 32'h0000_0100);
    chk("post_rst_fp_addr", bf.s_addr, 32'h0000_1004);
    // Both masters drop valid while granted; transactions must still complete
    m0_valid = 1'b0;
    m1_valid = 1'b0;
    tick();
    chk("drop_still_busy", br.s_valid, 1);
    s_ready = 1'b1;
    s_rdata = 32'h0BAD_F00D;
    #1;
    chk("drop_rr_m0_ready", br.m0_ready, 1);
    chk("drop_rr_m0_rdata", br.m0_rdata, 32'h0BAD_F00D);
    chk("drop_fp_m1_ready", bf.m1_ready, 1);
    tick();
    s_ready = 1'b0;
    #1;
    chk("drop_idle", br.s_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
